// File: rtl/nor_flash_pkg.sv
// Shared definitions for the NOR flash responder and the controller that drives it:
// command opcodes, status register bit positions and the command FSM states.
package nor_flash_pkg;

  localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS = 8'h70;
  localparam logic [7:0] CMD_READ_ID     = 8'h90;
  localparam logic [7:0] CMD_CLR_SR      = 8'h50;
  localparam logic [7:0] CMD_PROG        = 8'h10;
  localparam logic [7:0] CMD_PROG_ALT    = 8'h40;
  localparam logic [7:0] CMD_ERASE       = 8'h20;
  localparam logic [7:0] CMD_CONFIRM     = 8'hD0;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPP_ERR   = 3;

  localparam logic [7:0] SR_RESET = 8'h80;

  typedef enum logic [2:0] {
    ST_READ_ARRAY,
    ST_READ_STATUS,
    ST_READ_ID,
    ST_PROG_SETUP,
    ST_ERASE_SETUP,
    ST_PROG_BUSY,
    ST_ERASE_BUSY
  } state_e;

endpackage

// File: rtl/nor_flash_array.sv
// Word-addressed storage behind the responder: one synchronous port, read-first,
// so a read and a write to the same word in one cycle return the old contents.
module nor_flash_array #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata_q
);

  logic [15:0] mem [0:(1 << ADDR_W) - 1];

  // Single port: optional write plus registered read of the same word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

endmodule

// File: rtl/nor_flash_responder.sv
// Clocked NOR flash device model: decodes CE0/WE/OE/RP bus cycles into the flash
// command set and serves reads from a word array, status register or ID words.
module nor_flash_responder
  import nor_flash_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          BLK_W       = 4,
  parameter int          PROG_CYCLES = 16,
  parameter logic [15:0] MFR_ID      = 16'h0089,
  parameter logic [15:0] DEV_ID      = 16'h8816
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] A,
  inout  wire  [15:0] D,
  input  logic        CE0,
  input  logic        RP,
  input  logic        OE,
  input  logic        WE,
  output logic        busy,
  output logic [7:0]  dbg_sr
);

  // Counter serves both the program delay and the erase word walk; program needs PROG_CYCLES >= 2.
  localparam int PC_W  = $clog2(PROG_CYCLES);
  localparam int CNT_W = (BLK_W > PC_W) ? BLK_W : PC_W;

  logic              ce_q, we_q, oe_q;
  logic [ADDR_W-1:0] a_q;
  logic [15:0]       d_q;
  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pa_q, pa_d;
  logic [15:0]       pd_q, pd_d;
  logic [15:0]       rd_q, rd_d;

  logic              strobe_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [15:0]       ram_wdata_s;
  logic [15:0]       ram_rdata_s;
  logic [15:0]       dout_s;
  logic              rd_en_s;
  logic              unused_s;

  nor_flash_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (CLK),
    .we      (ram_we_s & RP),
    .addr    (ram_addr_s),
    .wdata   (ram_wdata_s),
    .rdata_q (ram_rdata_s)
  );

  // Command decode, program/erase sequencing and read-data selection.
  always_comb begin
    strobe_s    = !we_q && WE && !ce_q;
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    pa_d        = pa_q;
    pd_d        = pd_q;
    ram_we_s    = 1'b0;
    ram_addr_s  = A[ADDR_W-1:0];
    ram_wdata_s = 16'hFFFF;
    rd_d        = (state_q == ST_READ_ID) ? (A[0] ? DEV_ID : MFR_ID) : {8'h00, sr_q};

    case (state_q)
      ST_PROG_BUSY: begin
        // Old word is read at count 0 and becomes available for the AND-write at count 1.
        ram_addr_s  = pa_q;
        ram_we_s    = (cnt_q == CNT_W'(1));
        ram_wdata_s = pd_q & ram_rdata_s;
        cnt_d       = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PROG_CYCLES - 1)) begin
          sr_d[SR_READY] = 1'b1;
          state_d        = ST_READ_STATUS;
        end else begin
          state_d = ST_PROG_BUSY;
        end
      end
      ST_ERASE_BUSY: begin
        ram_addr_s = {pa_q[ADDR_W-1:BLK_W], cnt_q[BLK_W-1:0]};
        ram_we_s   = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q[BLK_W-1:0] == {BLK_W{1'b1}}) begin
          sr_d[SR_READY] = 1'b1;
          state_d        = ST_READ_STATUS;
        end else begin
          state_d = ST_ERASE_BUSY;
        end
      end
      ST_PROG_SETUP: begin
        if (strobe_s) begin
          pa_d           = a_q;
          pd_d           = d_q;
          cnt_d          = '0;
          sr_d[SR_READY] = 1'b0;
          state_d        = ST_PROG_BUSY;
        end else begin
          state_d = ST_PROG_SETUP;
        end
      end
      ST_ERASE_SETUP: begin
        if (strobe_s && (d_q[7:0] == CMD_CONFIRM)) begin
          pa_d           = a_q;
          cnt_d          = '0;
          sr_d[SR_READY] = 1'b0;
          state_d        = ST_ERASE_BUSY;
        end else if (strobe_s) begin
          sr_d[SR_ERASE_ERR] = 1'b1;
          sr_d[SR_PROG_ERR]  = 1'b1;
          state_d            = ST_READ_STATUS;
        end else begin
          state_d = ST_ERASE_SETUP;
        end
      end
      default: begin
        if (strobe_s) begin
          case (d_q[7:0])
            CMD_READ_ARRAY:         state_d = ST_READ_ARRAY;
            CMD_READ_STATUS:        state_d = ST_READ_STATUS;
            CMD_READ_ID:            state_d = ST_READ_ID;
            CMD_CLR_SR:             sr_d[SR_ERASE_ERR:SR_VPP_ERR] = 3'b000;
            CMD_PROG, CMD_PROG_ALT: state_d = ST_PROG_SETUP;
            CMD_ERASE:              state_d = ST_ERASE_SETUP;
            default:                state_d = state_q;
          endcase
        end else begin
          state_d = state_q;
        end
      end
    endcase
  end

  // Pin sampling and FSM state; RP low acts as a synchronous reset that aborts program/erase.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ce_q    <= 1'b1;
      we_q    <= 1'b1;
      oe_q    <= 1'b1;
      a_q     <= '1;
      d_q     <= 16'hFFFF;
      state_q <= ST_READ_ARRAY;
      sr_q    <= SR_RESET;
      cnt_q   <= '0;
      pa_q    <= '0;
      pd_q    <= 16'hFFFF;
      rd_q    <= {8'h00, SR_RESET};
    end else if (!RP) begin
      ce_q    <= 1'b1;
      we_q    <= 1'b1;
      oe_q    <= 1'b1;
      a_q     <= '1;
      d_q     <= 16'hFFFF;
      state_q <= ST_READ_ARRAY;
      sr_q    <= SR_RESET;
      cnt_q   <= '0;
      pa_q    <= '0;
      pd_q    <= 16'hFFFF;
      rd_q    <= {8'h00, SR_RESET};
    end else begin
      ce_q    <= CE0;
      we_q    <= WE;
      oe_q    <= OE;
      a_q     <= A[ADDR_W-1:0];
      d_q     <= D;
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      pa_q    <= pa_d;
      pd_q    <= pd_d;
      rd_q    <= rd_d;
    end
  end

  // Drive only on a clean read cycle; WE low with OE low never drives the bus.
  assign dout_s  = (state_q == ST_READ_ARRAY) ? ram_rdata_s : rd_q;
  assign rd_en_s = !CE0 && !OE && WE && RP && RESET;
  assign D       = rd_en_s ? dout_s : 16'hzzzz;

  assign busy     = ~sr_q[SR_READY];
  assign dbg_sr   = sr_q;
  assign unused_s = ^{oe_q, A[23:ADDR_W]};

endmodule

// File: tb/tb_nor_flash_responder.sv
// Directed and randomized bench for nor_flash_responder, checked against a
// word-level flash model (array contents, status byte and read mode).
module tb_nor_flash_responder;

  localparam int DEPTH = 256;
  localparam int BLK   = 16;
  localparam int M_ARRAY = 0, M_STATUS = 1, M_ID = 2, M_PSETUP = 3, M_ESETUP = 4, M_BUSY = 5;

  logic        CLK = 1'b0;
  logic        RESET, CE0, RP, OE, WE;
  logic [23:0] A;
  wire  [15:0] D;
  logic        busy;
  logic [7:0]  dbg_sr;
  logic [15:0] tb_d;
  logic        tb_den;

  int          checks = 0;
  int          errors = 0;
  int          mode_m;
  logic [7:0]  sr_m;
  logic [15:0] mem_m [DEPTH];

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (D[i]);
  end
  assign D = tb_den ? tb_d : 16'hzzzz;

  always #5 CLK = ~CLK;

  nor_flash_responder dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .A      (A),
    .D      (D),
    .CE0    (CE0),
    .RP     (RP),
    .OE     (OE),
    .WE     (WE),
    .busy   (busy),
    .dbg_sr (dbg_sr)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flash behaviour on an accepted write cycle, at the level of whole commands.
  function automatic void model_strobe(input logic [23:0] a, input logic [15:0] d);
    int w = int'(a) % DEPTH;
    case (mode_m)
      M_BUSY: ;
      M_PSETUP: begin
        mem_m[w] = mem_m[w] & d;
        mode_m   = M_BUSY;
      end
      M_ESETUP: begin
        if (d[7:0] == 8'hD0) begin
          for (int j = 0; j < BLK; j++) mem_m[(w / BLK) * BLK + j] = 16'hFFFF;
          mode_m = M_BUSY;
        end else begin
          sr_m   = sr_m | 8'h30;
          mode_m = M_STATUS;
        end
      end
      default: begin
        case (d[7:0])
          8'hFF:        mode_m = M_ARRAY;
          8'h70:        mode_m = M_STATUS;
          8'h90:        mode_m = M_ID;
          8'h50:        sr_m = sr_m & 8'hC7;
          8'h10, 8'h40: mode_m = M_PSETUP;
          8'h20:        mode_m = M_ESETUP;
          default:      ;
        endcase
      end
    endcase
  endfunction

  function automatic logic [15:0] exp_read(input logic [23:0] a);
    int w = int'(a) % DEPTH;
    case (mode_m)
      M_ARRAY: return mem_m[w];
      M_ID:    return (w % 2 == 0) ? 16'h0089 : 16'h8816;
      M_BUSY:  return {8'h00, sr_m & 8'h7F};
      default: return {8'h00, sr_m};
    endcase
  endfunction

  task automatic bus_write(input logic [23:0] a, input logic [15:0] d, input bit oe_lo);
    @(negedge CLK);
    A = a; tb_d = d; tb_den = 1'b1; CE0 = 1'b0; WE = 1'b0; OE = !oe_lo;
    #1;
    if (oe_lo) chk("oe_we_low_no_drive", D, d);
    @(negedge CLK);
    WE = 1'b1; CE0 = 1'b1;
    @(posedge CLK);
    #1;
    tb_den = 1'b0; OE = 1'b1;
    model_strobe(a, d);
  endtask

  task automatic read_check(input logic [23:0] a, input string tag);
    @(negedge CLK);
    A = a; CE0 = 1'b0; OE = 1'b0;
    repeat (2) @(negedge CLK);
    chk(tag, D, exp_read(a));
    CE0 = 1'b1; OE = 1'b1;
  endtask

  task automatic wait_ready(input int exp_len, input string tag);
    int n = 0;
    CE0 = 1'b0; OE = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge CLK);
      #1;
      n++;
      if (n == 3) chk({tag, "_status_busy"}, D, 16'h0000);
    end
    CE0 = 1'b1; OE = 1'b1;
    chk({tag, "_busy_len"}, 16'(n), 16'(exp_len));
    if (mode_m == M_BUSY) mode_m = M_STATUS;
  endtask

  task automatic program_word(input logic [23:0] a, input logic [15:0] v, input string tag);
    bus_write(a, ($urandom_range(0, 1) == 0) ? 16'h0010 : 16'h0040, 1'b0);
    bus_write(a, v, 1'b0);
    wait_ready(16, tag);
    chk({tag, "_sr"}, {8'h00, dbg_sr}, 16'h0080);
    bus_write(24'h0, 16'h00FF, 1'b0);
    read_check(a, {tag, "_data"});
  endtask

  initial begin
    logic [23:0] a;
    logic [15:0] save [BLK];
    RESET = 1'b0; RP = 1'b1; CE0 = 1'b1; WE = 1'b1; OE = 1'b1;
    A = 24'h0; tb_d = 16'h0000; tb_den = 1'b0;
    mode_m = M_ARRAY; sr_m = 8'h80;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_d_released", D, 16'hFFFF);
    chk("rst_sr", {8'h00, dbg_sr}, 16'h0080);
    chk("rst_busy", 16'(busy), 16'h0000);
    @(negedge CLK);
    RESET = 1'b1;

    // Reset mode is read array, so status must not appear on the bus.
    @(negedge CLK);
    A = 24'h0; CE0 = 1'b0; OE = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    assert (D !== 16'h0080) else begin
      errors++;
      $error("FAIL rst_read_array observed=%h expected=array word", D);
    end
    CE0 = 1'b1; OE = 1'b1;

    bus_write(24'h0, 16'h0020, 1'b0);
    bus_write(24'h0, 16'h00D0, 1'b0);
    wait_ready(16, "erase0");
    bus_write(24'h0, 16'h00FF, 1'b0);
    read_check(24'h3, "erase0_w3");

    bus_write(24'h3, 16'h0010, 1'b0);
    bus_write(24'h3, 16'hA5C3, 1'b0);
    wait_ready(16, "prog");
    chk("prog_sr", {8'h00, dbg_sr}, 16'h0080);
    bus_write(24'h0, 16'h00FF, 1'b0);
    read_check(24'h3, "prog_w3");
    bus_write(24'h3, 16'h0040, 1'b0);
    bus_write(24'h3, 16'h0F0F, 1'b0);
    wait_ready(16, "reprog");
    bus_write(24'h0, 16'h00FF, 1'b0);
    read_check(24'h3, "reprog_w3");

    bus_write(24'h5, 16'h0020, 1'b0);
    bus_write(24'h5, 16'h00FF, 1'b0);
    chk("seqerr_sr", {8'h00, dbg_sr}, 16'h00B0);
    read_check(24'h5, "seqerr_status");
    bus_write(24'h0, 16'h00FF, 1'b0);
    read_check(24'h5, "seqerr_nochange");
    bus_write(24'h0, 16'h0050, 1'b0);
    chk("clr_sr", {8'h00, dbg_sr}, 16'h0080);

    bus_write(24'h0, 16'h0090, 1'b0);
    read_check(24'h0, "id_mfr");
    read_check(24'h1, "id_dev");
    a = {16'($urandom), 8'h01};
    read_check(a, "id_alias");

    bus_write(24'h20, 16'h0020, 1'b0);
    bus_write(24'h20, 16'h00D0, 1'b0);
    bus_write(24'h0, 16'h0090, 1'b0);
    wait_ready(14, "erase2_ign");
    read_check(24'h0, "ign_status");

    bus_write(24'h7, 16'h00FF, 1'b1);
    read_check({16'($urandom), 8'h03}, "oe_wr_array");

    bus_write(24'h10, 16'h0020, 1'b0);
    bus_write(24'h10, 16'h00D0, 1'b0);
    wait_ready(16, "erase1");
    for (int i = 0; i < BLK; i++) program_word(24'(16 + i), 16'($urandom), "fill");
    for (int i = 0; i < 8; i++) begin
      a = {16'($urandom), 8'(16 + $urandom_range(0, BLK - 1))};
      program_word(a, 16'($urandom), "rand_prog");
    end

    // Abort an erase after five words with RP; the rest of the block is untouched.
    for (int i = 0; i < BLK; i++) save[i] = mem_m[16 + i];
    bus_write(24'h10, 16'h0020, 1'b0);
    bus_write(24'h10, 16'h00D0, 1'b0);
    repeat (5) @(posedge CLK);
    #1;
    RP = 1'b0;
    @(posedge CLK);
    #1;
    chk("abort_busy", 16'(busy), 16'h0000);
    chk("abort_sr", {8'h00, dbg_sr}, 16'h0080);
    RP = 1'b1;
    for (int i = 5; i < BLK; i++) mem_m[16 + i] = save[i];
    mode_m = M_ARRAY; sr_m = 8'h80;
    for (int i = 0; i < BLK; i++) read_check(24'(16 + i), "abort_word");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
